hex_7seg_decoder: RTL and testbench

HEX_7SEG_DECODER -- requirements
Module: hex_7seg_decoder

---
 rtl/hex_7seg_decoder.sv | 73 +++++++
 tb/tb_hex_7seg_decoder.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/hex_7seg_decoder.sv
// Registered hex-to-7-segment decoder with lamp test and blanking, one cycle of latency.
// Define HEX7SEG_ACTIVE_LOW_EN for common-anode panels (lit segment = 0, reset = all 1).
module hex_7seg_decoder (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] in,
    input  logic       i_blank,
    input  logic       i_lamp_test,
    output logic       o_a,
    output logic       o_b,
    output logic       o_c,
    output logic       o_d,
    output logic       o_e,
    output logic       o_f,
    output logic       o_g
);

    logic [6:0] pattern;
    logic [6:0] seg_next;
    logic [6:0] seg_phys_next;
    logic [6:0] seg_q;

    // Bit order is {a,b,c,d,e,f,g}, 1 = lit.
    always_comb begin
        pattern = 7'b0000000;
        case (in)
            4'h0: pattern = 7'b1111110;
            4'h1: pattern = 7'b0110000;
            4'h2: pattern = 7'b1101101;
            4'h3: pattern = 7'b1111001;
            4'h4: pattern = 7'b0110011;
            4'h5: pattern = 7'b1011011;
            4'h6: pattern = 7'b1011111;
            4'h7: pattern = 7'b1110000;
            4'h8: pattern = 7'b1111111;
            4'h9: pattern = 7'b1111011;
            4'hA: pattern = 7'b1110111;
            4'hB: pattern = 7'b0011111;
            4'hC: pattern = 7'b1001110;
            4'hD: pattern = 7'b0111101;
            4'hE: pattern = 7'b1001111;
            4'hF: pattern = 7'b1000111;
            default: pattern = 7'b0000000;
        endcase
    end

    always_comb begin
        seg_next = pattern;
        if (i_lamp_test)
            seg_next = 7'b1111111;
        else if (i_blank)
            seg_next = 7'b0000000;
    end

`ifdef HEX7SEG_ACTIVE_LOW_EN
    localparam logic [6:0] SEG_DARK = 7'b1111111;
    assign seg_phys_next = ~seg_next;
`else
    localparam logic [6:0] SEG_DARK = 7'b0000000;
    assign seg_phys_next = seg_next;
`endif

    // Polarity is applied before the register so the pins come straight off flops.
    always_ff @(posedge clk) begin
        if (rst)
            seg_q <= SEG_DARK;
        else
            seg_q <= seg_phys_next;
    end

    assign {o_a, o_b, o_c, o_d, o_e, o_f, o_g} = seg_q;

endmodule

// File: tb/tb_hex_7seg_decoder.sv
// Self-checking bench for hex_7seg_decoder: vector table, mid-cycle hold case, random vs. reference model.
module tb_hex_7seg_decoder;

    logic       clk;
    logic       rst;
    logic [3:0] in;
    logic       i_blank;
    logic       i_lamp_test;
    logic       o_a, o_b, o_c, o_d, o_e, o_f, o_g;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic       rst;
        logic       lamp;
        logic       blank;
        logic [3:0] digit;
        logic [6:0] exp_logical;
        string      name;
    } vec_t;

    vec_t vecs[$];

    // Reference segment table {a,b,c,d,e,f,g} for each hex digit.
    logic [6:0] ref_table [16];

    hex_7seg_decoder dut (
        .clk         (clk),
        .rst         (rst),
        .in          (in),
        .i_blank     (i_blank),
        .i_lamp_test (i_lamp_test),
        .o_a         (o_a),
        .o_b         (o_b),
        .o_c         (o_c),
        .o_d         (o_d),
        .o_e         (o_e),
        .o_f         (o_f),
        .o_g         (o_g)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] to_phys(input logic [6:0] logical);
`ifdef HEX7SEG_ACTIVE_LOW_EN
        return ~logical;
`else
        return logical;
`endif
    endfunction

    function automatic logic [6:0] model(input logic r, input logic lamp, input logic blank,
                                         input logic [3:0] d);
        if (r)          return 7'b0000000;
        else if (lamp)  return 7'b1111111;
        else if (blank) return 7'b0000000;
        else            return ref_table[d];
    endfunction

    task automatic check(input string name, input logic [6:0] exp_phys);
        logic [6:0] got;
        got = {o_a, o_b, o_c, o_d, o_e, o_f, o_g};
        n_total++;
        if (got === exp_phys)
            n_pass++;
        else
            $display("FAIL %s: got %b expected %b", name, got, exp_phys);
    endtask

    task automatic drive(input logic r, input logic lamp, input logic blank, input logic [3:0] d);
        rst         = r;
        i_lamp_test = lamp;
        i_blank     = blank;
        in          = d;
    endtask

    function automatic vec_t mk(input logic r, input logic lamp, input logic blank,
                                input logic [3:0] d, input logic [6:0] e, input string n);
        vec_t v;
        v.rst = r; v.lamp = lamp; v.blank = blank; v.digit = d; v.exp_logical = e; v.name = n;
        return v;
    endfunction

    initial begin
        logic r, lamp, blank;
        logic [3:0] d;

        ref_table = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                      7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                      7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                      7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

        vecs.push_back(mk(1, 1, 0, 4'h8, 7'b0000000, "reset_edge1"));
        vecs.push_back(mk(1, 1, 0, 4'h8, 7'b0000000, "reset_edge2"));
        vecs.push_back(mk(0, 1, 0, 4'h8, 7'b1111111, "reset_release"));
        vecs.push_back(mk(0, 0, 0, 4'h0, 7'b1111110, "sweep_0"));
        vecs.push_back(mk(0, 0, 0, 4'h1, 7'b0110000, "sweep_1"));
        vecs.push_back(mk(0, 0, 0, 4'h2, 7'b1101101, "sweep_2"));
        vecs.push_back(mk(0, 0, 0, 4'h3, 7'b1111001, "sweep_3"));
        vecs.push_back(mk(0, 0, 0, 4'h4, 7'b0110011, "sweep_4"));
        vecs.push_back(mk(0, 0, 0, 4'h5, 7'b1011011, "sweep_5"));
        vecs.push_back(mk(0, 0, 0, 4'h6, 7'b1011111, "sweep_6"));
        vecs.push_back(mk(0, 0, 0, 4'h7, 7'b1110000, "sweep_7"));
        vecs.push_back(mk(0, 0, 0, 4'h8, 7'b1111111, "sweep_8"));
        vecs.push_back(mk(0, 0, 0, 4'h9, 7'b1111011, "sweep_9"));
        vecs.push_back(mk(0, 0, 0, 4'hA, 7'b1110111, "sweep_A"));
        vecs.push_back(mk(0, 0, 0, 4'hB, 7'b0011111, "sweep_B"));
        vecs.push_back(mk(0, 0, 0, 4'hC, 7'b1001110, "sweep_C"));
        vecs.push_back(mk(0, 0, 0, 4'hD, 7'b0111101, "sweep_D"));
        vecs.push_back(mk(0, 0, 0, 4'hE, 7'b1001111, "sweep_E"));
        vecs.push_back(mk(0, 0, 0, 4'hF, 7'b1000111, "sweep_F"));
        vecs.push_back(mk(0, 0, 1, 4'h1, 7'b0000000, "blank_on"));
        vecs.push_back(mk(0, 0, 0, 4'h1, 7'b0110000, "blank_off"));
        vecs.push_back(mk(0, 1, 1, 4'h1, 7'b1111111, "lamp_over_blank"));
        vecs.push_back(mk(0, 0, 1, 4'h1, 7'b0000000, "lamp_drop"));
        vecs.push_back(mk(0, 0, 0, 4'h0, 7'b1111110, "digit_0_again"));
        vecs.push_back(mk(0, 0, 0, 4'h7, 7'b1110000, "digit_7_again"));
        vecs.push_back(mk(1, 0, 0, 4'h7, 7'b0000000, "reset_midrun"));
        vecs.push_back(mk(0, 0, 0, 4'h7, 7'b1110000, "after_reset_7"));

        drive(1, 0, 0, 4'h0);
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].lamp, vecs[i].blank, vecs[i].digit);
            @(posedge clk); #1;
            check(vecs[i].name, to_phys(vecs[i].exp_logical));
        end

        // Mid-cycle input change must not reach the outputs before the next edge.
        drive(0, 0, 0, 4'h3);
        @(posedge clk); #1;
        check("mid_pre", to_phys(7'b1111001));
        #2 in = 4'h4;
        #1 check("mid_hold", to_phys(7'b1111001));
        @(posedge clk); #1;
        check("mid_update", to_phys(7'b0110011));
        repeat (3) begin
            @(posedge clk); #1;
            check("stable_hold", to_phys(7'b0110011));
        end

        for (int k = 0; k < 300; k++) begin
            r     = ($urandom_range(0, 19) == 0);
            lamp  = ($urandom_range(0, 7) == 0);
            blank = ($urandom_range(0, 5) == 0);
            d     = 4'($urandom_range(0, 15));
            drive(r, lamp, blank, d);
            @(posedge clk); #1;
            check("random", to_phys(model(r, lamp, blank, d)));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
